// File: rtl/mult_div_unit.sv
// Purpose: multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Latency: Busy high for exactly MULT_CYCLES/DIV_CYCLES cycles after the accepting edge; HI/LO update as Busy falls.
// Backpressure: none internally; Start/MTHI/MTLO are ignored while Busy=1, so the hazard unit must stall.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   MDUSrcA, MDUSrcB  - forwarded rs / rt operands, sampled only at the accepting edge
//   MDUOp, Start      - operation code and one-cycle start pulse for mult/multu/div/divu
//   Busy              - operation in flight
//   HI, LO            - architectural HI/LO registers
//   MDUResult_E       - combinational MFHI/MFLO read data (0 for any other op)
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] MDUSrcA,
   input  logic [31:0] MDUSrcB,
   input  logic [3:0]  MDUOp,
   input  logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUResult_E
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [31:0]        pend_hi_q, pend_lo_q;
   logic               pend_wr_q;

   logic               op_is_md;
   logic               accept;
   logic               last_cycle;

   // ---------------- arithmetic (evaluated on the live operands) ----------------
   logic [63:0] prod_s, prod_u;
   logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
   logic [31:0] sq_mag, sr_mag, s_quot, s_rem, u_quot, u_rem;
   logic        b_zero;

   // Sign-extending to 64 bits makes the low 64 bits of an unsigned product equal the signed product.
   assign prod_s = {{32{MDUSrcA[31]}}, MDUSrcA} * {{32{MDUSrcB[31]}}, MDUSrcB};
   assign prod_u = {32'd0, MDUSrcA} * {32'd0, MDUSrcB};

   // Divisor forced to 1 on zero so the divider never sees x/0; the result is discarded anyway.
   assign b_zero     = (MDUSrcB == 32'd0);
   assign b_safe     = b_zero ? 32'd1 : MDUSrcB;
   assign a_mag      = MDUSrcA[31] ? (~MDUSrcA + 32'd1) : MDUSrcA;
   assign b_mag      = MDUSrcB[31] ? (~MDUSrcB + 32'd1) : MDUSrcB;
   assign b_mag_safe = b_zero ? 32'd1 : b_mag;

   // Signed divide through magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0
   // because the unsigned magnitude 0x80000000 negates to itself.
   assign sq_mag = a_mag / b_mag_safe;
   assign sr_mag = a_mag % b_mag_safe;
   assign s_quot = (MDUSrcA[31] ^ MDUSrcB[31]) ? (~sq_mag + 32'd1) : sq_mag;
   assign s_rem  = MDUSrcA[31] ? (~sr_mag + 32'd1) : sr_mag;
   assign u_quot = MDUSrcA / b_safe;
   assign u_rem  = MDUSrcA % b_safe;

   assign op_is_md   = (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);
   assign accept     = (state_q == S_IDLE) && Start && op_is_md;
   assign last_cycle = (cnt_q == CNT_W'(1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept)     state_d = S_RUN;
         S_RUN:   if (last_cycle) state_d = S_IDLE;
         default:                 state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      Busy = (state_q == S_RUN);
   end

   // ---------------- datapath: counter, pending result, HI/LO ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
         HI        <= '0;
         LO        <= '0;
      end else if (state_q == S_IDLE) begin
         if (accept) begin
            pend_wr_q <= 1'b1;
            case (MDUOp)
               OP_MULT: begin
                  {pend_hi_q, pend_lo_q} <= prod_s;
                  cnt_q                  <= CNT_W'(MULT_CYCLES);
               end
               OP_MULTU: begin
                  {pend_hi_q, pend_lo_q} <= prod_u;
                  cnt_q                  <= CNT_W'(MULT_CYCLES);
               end
               OP_DIV: begin
                  pend_hi_q <= s_rem;
                  pend_lo_q <= s_quot;
                  pend_wr_q <= !b_zero;
                  cnt_q     <= CNT_W'(DIV_CYCLES);
               end
               default: begin
                  pend_hi_q <= u_rem;
                  pend_lo_q <= u_quot;
                  pend_wr_q <= !b_zero;
                  cnt_q     <= CNT_W'(DIV_CYCLES);
               end
            endcase
         end else if (!Start && MDUOp == OP_MTHI) begin
            HI <= MDUSrcA;
         end else if (!Start && MDUOp == OP_MTLO) begin
            LO <= MDUSrcA;
         end
      end else begin
         cnt_q <= cnt_q - CNT_W'(1);
         if (last_cycle && pend_wr_q) begin
            HI <= pend_hi_q;
            LO <= pend_lo_q;
         end
      end
   end

   // ---------------- read port ----------------
   always_comb begin
      MDUResult_E = 32'd0;
      if (MDUOp == OP_MFHI)      MDUResult_E = HI;
      else if (MDUOp == OP_MFLO) MDUResult_E = LO;
   end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] MDUSrcA, MDUSrcB;
   logic [3:0]  MDUOp;
   logic        Start;
   logic        Busy;
   logic [31:0] HI, LO, MDUResult_E;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk         (clk),
      .reset       (reset),
      .MDUSrcA     (MDUSrcA),
      .MDUSrcB     (MDUSrcB),
      .MDUOp       (MDUOp),
      .Start       (Start),
      .Busy        (Busy),
      .HI          (HI),
      .LO          (LO),
      .MDUResult_E (MDUResult_E)
   );

   always #5 clk = ~clk;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] m_hi, m_lo;        // bench model of HI/LO
   logic [63:0] sb_q[$];           // expected {HI,LO} per accepted operation

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] val);
      MDUOp = op; Start = 1'b0; MDUSrcA = val;
      step();
      MDUOp = 4'd0;
      if (op == 4'd7) m_hi = val;
      else            m_lo = val;
   endtask

   // Issue one op, optionally inject a stray op/Start at busy cycle inj_cyc,
   // then check hold behaviour, busy length and the scoreboarded result.
   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int n, input int inj_cyc,
                         input logic [3:0] inj_op, input logic inj_start);
      int          cnt;
      logic [63:0] e;
      sb_q.push_back({exp_hi, exp_lo});
      MDUOp = op; Start = 1'b1; MDUSrcA = a; MDUSrcB = b;
      step();
      // Operands change after acceptance; must have no effect.
      Start = 1'b0; MDUOp = 4'd0; MDUSrcA = 32'h1234_5678; MDUSrcB = 32'h0000_0003;
      cnt = 0;
      while (Busy === 1'b1 && cnt < 200) begin
         check({tag, "_hold_hi"}, HI, m_hi);
         check({tag, "_hold_lo"}, LO, m_lo);
         if (cnt == inj_cyc) begin
            MDUOp = inj_op; Start = inj_start; MDUSrcA = 32'h0000_0055; MDUSrcB = 32'h0000_0002;
         end
         step();
         MDUOp = 4'd0; Start = 1'b0;
         cnt++;
      end
      check({tag, "_busy_len"}, 32'(cnt), 32'(n));
      e = sb_q.pop_front();
      check({tag, "_hi"}, HI, e[63:32]);
      check({tag, "_lo"}, LO, e[31:0]);
      m_hi = e[63:32];
      m_lo = e[31:0];
   endtask

   initial begin
      reset = 1'b1; MDUSrcA = '0; MDUSrcB = '0; MDUOp = 4'd0; Start = 1'b0;
      m_hi = '0; m_lo = '0;
      step(); step();
      reset = 1'b0;
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      check("rst_result", MDUResult_E, 32'd0);

      run_op("mult",  4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, -1, 4'd0, 1'b0);
      run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, -1, 4'd0, 1'b0);
      run_op("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, -1, 4'd0, 1'b0);
      run_op("divu",  4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10, -1, 4'd0, 1'b0);
      run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, -1, 4'd0, 1'b0);

      mt(4'd7, 32'h0000_0011);
      mt(4'd8, 32'h0000_0022);
      check("mthi_11", HI, 32'h0000_0011);
      check("mtlo_22", LO, 32'h0000_0022);
      run_op("divu_by0", 4'd4, 32'd5, 32'd0, 32'h0000_0011, 32'h0000_0022, 10, -1, 4'd0, 1'b0);

      mt(4'd7, 32'hDEAD_BEEF);
      check("mthi_dead", HI, 32'hDEAD_BEEF);
      MDUOp = 4'd5; #1;
      check("mfhi", MDUResult_E, 32'hDEAD_BEEF);
      MDUOp = 4'd6; #1;
      check("mflo", MDUResult_E, 32'h0000_0022);
      MDUOp = 4'd0; #1;
      check("none_result", MDUResult_E, 32'd0);

      // MTLO during busy must be ignored.
      run_op("mult_mtlo", 4'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5, 2, 4'd8, 1'b0);
      // Start during busy must neither restart nor stretch the operation.
      run_op("divu_restart", 4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10, 3, 4'd1, 1'b1);

      // Reset in the middle of a DIV discards the pending result.
      MDUOp = 4'd3; Start = 1'b1; MDUSrcA = 32'd100; MDUSrcB = 32'd7;
      step();
      Start = 1'b0; MDUOp = 4'd0;
      check("rstmid_busy_pre", {31'd0, Busy}, 32'd1);
      repeat (3) step();
      reset = 1'b1;
      step();
      check("rstmid_busy", {31'd0, Busy}, 32'd0);
      check("rstmid_hi", HI, 32'd0);
      check("rstmid_lo", LO, 32'd0);
      reset = 1'b0;
      repeat (12) step();
      check("rstmid_busy_after", {31'd0, Busy}, 32'd0);
      check("rstmid_hi_after", HI, 32'd0);
      check("rstmid_lo_after", LO, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage, beside the single-cycle ALU.
- Executes mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Owns the architectural HI/LO registers.
- Exposes Busy so the hazard unit stalls later MDU instructions in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, Busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- MDUSrcA  input  32  forwarded rs value.
- MDUSrcB  input  32  forwarded rt value.
- MDUOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; other codes act as NONE.
- Start  input  1  one-cycle pulse from E-stage control with MDUOp in 1..4.
- Busy  output  1  high while an operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- MDUResult_E  output  32  combinational: HI when MDUOp=MFHI, LO when MDUOp=MFLO, else 0.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, and overrides everything. On reset: HI=0, LO=0, Busy=0, counter=0, pending result cleared.
- States:
  - IDLE (Busy=0): Start with MDUOp 1..4 is accepted at the clock edge.
    - Operands are computed and latched into pending HI/LO.
    - Counter loads MULT_CYCLES or DIV_CYCLES; go to RUN.
    - Start with any other MDUOp is ignored.
  - RUN (Busy=1): counter decrements every edge.
    - At the edge where counter==1, pending values are written to HI/LO, Busy falls and the state returns to IDLE.
- Latency:
  - Busy is high for exactly N cycles after the accepting edge.
  - New HI/LO values are visible in the first cycle Busy=0.
  - During RUN, HI/LO keep their old values.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = signed quotient, truncated toward zero; HI = remainder, sign of dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0, either div op): operation still runs DIV_CYCLES with Busy high, but HI/LO are left unchanged at completion.
- MTHI/MTLO:
  - Write MDUSrcA into HI/LO at the next edge, only when Busy=0 and Start=0.
  - Ignored while Busy=1.
- Start while Busy=1: ignored. No restart, no queueing; the hazard unit must stall.
- Reads: MDUResult_E reads the current HI/LO combinationally. An MFHI/MFLO while Busy=1 returns the stale value; the hazard unit is responsible for stalling it.
- Operand handling: MDUSrcA/B are sampled only at the accepting edge; later changes have no effect.
- Reset mid-operation: aborts the operation; the pending result is discarded; HI=LO=0 on the next cycle.
- Start and MTHI/MTLO are mutually exclusive by decode: MDUOp carries one code, and MTHI/MTLO writes require Start=0.
- Pipeline flush: no flush input. An operation already accepted always completes.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE (-2), B=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO keep their old values until then.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat with DIVU A=7, B=2 -> LO=3, HI=1.
- Edge divides:
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - DIVU by B=0 with HI=0x11, LO=0x22 -> Busy 10 cycles, HI/LO still 0x11/0x22.
- MTHI 0xDEADBEEF with Busy=0 -> HI=0xDEADBEEF next cycle; MFHI returns it on MDUResult_E. MTLO issued during Busy -> ignored. Start during Busy -> ignored, Busy still falls at the original count.
- Start a DIV, assert reset at cycle 4 -> next cycle Busy=0, HI=LO=0, and the pending result is never written.
